// File: rtl/mac_job_sched.sv
// Round-robin job scheduler sharing one MAC engine among N_CORES cores.
// Optional watchdog on the RUN phase: define MAC_JOB_SCHED_WATCHDOG_EN.
module mac_job_sched #(
    parameter int N_CORES   = 2,
    parameter int N_CONTEXT = 2,
    parameter int CNT_W     = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               clear_i,
    input  logic [N_CORES-1:0]                 req_i,
    input  logic [N_CORES-1:0][31:0]           req_nb_iter_i,
    input  logic [N_CORES-1:0][CNT_W-1:0]      req_len_i,
    input  logic [N_CORES-1:0][31:0]           req_mu_i,
    output logic [N_CORES-1:0]                 gnt_o,
    output logic                               start_o,
    output logic [31:0]                        job_nb_iter_o,
    output logic [CNT_W-1:0]                   job_len_o,
    output logic [31:0]                        job_mu_o,
    input  logic                               done_i,
    output logic                               busy_o,
    output logic [N_CORES-1:0]                 evt_o,
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
    input  logic [CNT_W-1:0]                   wd_limit_i,
    output logic [N_CORES-1:0]                 timeout_o,
`endif
    output logic [$clog2(N_CONTEXT+1)-1:0]     fifo_cnt_o
);

    localparam int ID_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int PTR_W  = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
    localparam int CNT_FW = $clog2(N_CONTEXT + 1);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [31:0]      nb_iter;
        logic [CNT_W-1:0] len;
        logic [31:0]      mu;
    } job_t;

    typedef enum logic [1:0] {IDLE, DISPATCH, RUN, DONE} state_t;

    state_t           state_q;
    job_t             mem_q [N_CONTEXT];
    job_t             head;
    job_t             wr_job;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_FW-1:0] cnt_q;
    logic [ID_W-1:0]  rr_q;
    logic [ID_W-1:0]  owner_q;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_vld;
    logic             full;
    logic             push;
    logic             pop;
    logic             clr;
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
    logic [CNT_W-1:0] wd_cnt_q;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_CONTEXT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Two passes give "first requester at or after rr_q, wrapping".
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (!gnt_vld && req_i[i] && (ID_W'(i) >= rr_q)) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'(i);
            end
        end
        for (int i = 0; i < N_CORES; i++) begin
            if (!gnt_vld && req_i[i]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'(i);
            end
        end
    end

    assign clr    = rst_i | clear_i;
    assign full   = (cnt_q == CNT_FW'(N_CONTEXT));
    assign push   = gnt_vld & ~full & ~clr;
    assign pop    = ((state_q == IDLE) | (state_q == DONE)) & (cnt_q != '0);
    assign head   = mem_q[rd_ptr_q];
    assign wr_job = '{gnt_id, req_nb_iter_i[gnt_id],
                      req_len_i[gnt_id], req_mu_i[gnt_id]};

    assign gnt_o      = push ? (N_CORES'(1) << gnt_id) : '0;
    assign fifo_cnt_o = cnt_q;
    assign busy_o     = (state_q != IDLE) | (cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_job;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            rr_q          <= '0;
            owner_q       <= '0;
            start_o       <= 1'b0;
            evt_o         <= '0;
            job_nb_iter_o <= '0;
            job_len_o     <= '0;
            job_mu_o      <= '0;
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
            wd_cnt_q      <= '0;
            timeout_o     <= '0;
`endif
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
                rr_q     <= (gnt_id == ID_W'(N_CORES - 1)) ? '0 : gnt_id + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
            start_o <= 1'b0;
            evt_o   <= '0;
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
            timeout_o <= '0;
`endif
            unique case (state_q)
                IDLE, DONE: begin
                    if (pop) begin
                        state_q       <= DISPATCH;
                        start_o       <= 1'b1;
                        owner_q       <= head.id;
                        job_nb_iter_o <= head.nb_iter;
                        job_len_o     <= head.len;
                        job_mu_o      <= head.mu;
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
                        wd_cnt_q      <= '0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DISPATCH: state_q <= RUN;
                RUN: begin
                    if (done_i) begin
                        state_q <= DONE;
                        evt_o   <= N_CORES'(1) << owner_q;
                    end
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
                    // A done_i on the limit cycle wins over the timeout.
                    else if ((wd_limit_i != '0) &&
                             (wd_cnt_q + 1'b1 == wd_limit_i)) begin
                        state_q   <= DONE;
                        evt_o     <= N_CORES'(1) << owner_q;
                        timeout_o <= N_CORES'(1) << owner_q;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_job_sched.sv
// Bench for mac_job_sched: directed scenarios plus random traffic,
// all checked every cycle against a queue-based job model.
module tb_mac_job_sched;

    localparam int N    = 2;
    localparam int NCTX = 2;
    localparam int CW   = 16;
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                  rst_i, clear_i, done_i;
    logic [N-1:0]          req_i;
    logic [N-1:0][31:0]    nb_in, mu_in;
    logic [N-1:0][CW-1:0]  len_in;
    logic [N-1:0]          gnt, evt;
    logic                  start, busy;
    logic [31:0]           job_nb, job_mu;
    logic [CW-1:0]         job_len;
    logic [$clog2(NCTX+1)-1:0] fifo_cnt;
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
    logic [CW-1:0]         wd_limit;
    logic [N-1:0]          timeout;
`endif

    mac_job_sched #(.N_CORES(N), .N_CONTEXT(NCTX), .CNT_W(CW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .req_i         (req_i),
        .req_nb_iter_i (nb_in),
        .req_len_i     (len_in),
        .req_mu_i      (mu_in),
        .gnt_o         (gnt),
        .start_o       (start),
        .job_nb_iter_o (job_nb),
        .job_len_o     (job_len),
        .job_mu_o      (job_mu),
        .done_i        (done_i),
        .busy_o        (busy),
        .evt_o         (evt),
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
        .wd_limit_i    (wd_limit),
        .timeout_o     (timeout),
`endif
        .fifo_cnt_o    (fifo_cnt)
    );

    typedef struct {
        int          id;
        logic [31:0] nb;
        logic [CW-1:0] len;
        logic [31:0] mu;
    } mjob_t;

    // Model: queued jobs, the active job and its lifecycle phase
    // (0 idle, 1 start cycle, 2 running, 3 completion cycle).
    mjob_t mq[$];
    mjob_t m_cur;
    int    m_phase, m_rr, m_age;
    bit    m_to;

    logic [N-1:0] pend;
    int    mode [N];
    int    lat;
    int    wdl;
    int    checks = 0;
    int    errors = 0;

    logic [N-1:0]  s_gnt, s_evt, s_to;
    logic          s_start, s_busy;
    logic [1:0]    s_cnt;
    logic [31:0]   s_nb, s_mu;
    logic [CW-1:0] s_len;
    logic [N-1:0]  gq[$];
    logic [N-1:0]  eq[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_desc(input int c);
        nb_in[IW'(c)]  = $urandom;
        len_in[IW'(c)] = CW'($urandom);
        mu_in[IW'(c)]  = $urandom;
        pend[IW'(c)]   = 1'b1;
    endtask

    task automatic cycle();
        int gid;
        logic [N-1:0] eg;
        for (int c = 0; c < N; c++) begin
            if (!pend[IW'(c)] && (mode[IW'(c)] == 1 ||
                (mode[IW'(c)] == 2 && $urandom_range(0, 3) == 0)))
                new_desc(c);
        end
        req_i = pend;
        if (lat >= 0) done_i = (m_phase == 2 && m_age == lat);
        else if (lat == -2) done_i = ($urandom_range(0, 4) == 0);
        gid = -1;
        if (!rst_i && !clear_i && mq.size() < NCTX) begin
            for (int k = 0; k < N; k++) begin
                int c = (m_rr + k) % N;
                if (gid < 0 && pend[IW'(c)]) gid = c;
            end
        end
        eg = (gid >= 0) ? (N'(1) << gid) : '0;
        #2;
        s_gnt = gnt; s_evt = evt; s_start = start; s_busy = busy;
        s_cnt = fifo_cnt; s_nb = job_nb; s_len = job_len; s_mu = job_mu;
        s_to = '0;
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
        s_to = timeout;
`endif
        chk("gnt", s_gnt, eg);
        chk("start", s_start, m_phase == 1);
        chk("evt", s_evt, (m_phase == 3) ? (N'(1) << m_cur.id) : '0);
        chk("busy", s_busy, (m_phase != 0) || (mq.size() != 0));
        chk("cnt", s_cnt, mq.size());
        chk("job_nb", s_nb, m_cur.nb);
        chk("job_len", s_len, m_cur.len);
        chk("job_mu", s_mu, m_cur.mu);
        if (WD) chk("timeout", s_to,
                    (m_phase == 3 && m_to) ? (N'(1) << m_cur.id) : '0);
        if (rst_i || clear_i) begin
            mq.delete();
            m_phase = 0;
            m_rr    = 0;
            m_to    = 0;
            m_cur   = '{id: 0, nb: 0, len: 0, mu: 0};
        end else begin
            mjob_t nj;
            if (m_phase == 0 || m_phase == 3) begin
                if (mq.size() > 0) begin
                    m_cur   = mq.pop_front();
                    m_phase = 1;
                end else begin
                    m_phase = 0;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
                m_age   = 1;
            end else if (done_i) begin
                m_phase = 3;
                m_to    = 0;
            end else if (WD && wdl != 0 && m_age == wdl) begin
                m_phase = 3;
                m_to    = 1;
            end else begin
                m_age++;
            end
            if (gid >= 0) begin
                nj = '{id: gid, nb: nb_in[IW'(gid)],
                       len: len_in[IW'(gid)], mu: mu_in[IW'(gid)]};
                mq.push_back(nj);
                m_rr = (gid + 1) % N;
                pend[IW'(gid)] = 1'b0;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        pend = '0;
        for (int c = 0; c < N; c++) mode[IW'(c)] = 0;
        lat = -1;
        done_i = 1'b0;
        rst_i = 1'b1;
        cycle();
        cycle();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; done_i = 1'b0; req_i = '0;
        nb_in = '0; len_in = '0; mu_in = '0; pend = '0;
        lat = -1; wdl = 0;
        m_phase = 0; m_rr = 0; m_age = 0; m_to = 0;
        m_cur = '{id: 0, nb: 0, len: 0, mu: 0};
        for (int c = 0; c < N; c++) mode[IW'(c)] = 0;
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
        wd_limit = '0;
`endif
        @(posedge clk_i);
        #1;
        do_reset();
        chk("rst_cnt", s_cnt, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_start", s_start, 0);
        chk("rst_evt", s_evt, 0);

        // Single job: 3/8/5 on core 0, done_i 10 cycles after start.
        lat = 10;
        nb_in[0] = 32'd3; len_in[0] = CW'(8); mu_in[0] = 32'd5;
        pend[0] = 1'b1;
        cycle();
        chk("sj_gnt", s_gnt, 2'b01);
        cycle();
        chk("sj_nostart", s_start, 0);
        cycle();
        chk("sj_start", s_start, 1);
        chk("sj_nb", s_nb, 3);
        chk("sj_len", s_len, 8);
        chk("sj_mu", s_mu, 5);
        repeat (10) cycle();
        cycle();
        chk("sj_evt", s_evt, 2'b01);
        cycle();
        chk("sj_idle", s_busy, 0);

        // Fairness: both cores requesting continuously.
        do_reset();
        lat = 4;
        mode[0] = 1; mode[1] = 1;
        gq.delete(); eq.delete();
        repeat (40) begin
            cycle();
            if (s_gnt != '0) gq.push_back(s_gnt);
            if (s_evt != '0) eq.push_back(s_evt);
        end
        chk("fair_ngnt", gq.size() >= 4, 1);
        chk("fair_nevt", eq.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            chk("fair_gnt", gq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("fair_evt", eq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        // FIFO full while job 1 runs, then grant after the next pop.
        do_reset();
        lat = 20;
        new_desc(0);
        for (int c = 0; c < 27; c++) begin
            if (c == 2) begin mode[0] = 1; mode[1] = 1; end
            cycle();
            if (c == 0) chk("ff_gnt0", s_gnt, 2'b01);
            if (c == 2) begin
                chk("ff_start", s_start, 1);
                chk("ff_gnt2", s_gnt, 2'b10);
            end
            if (c == 3) chk("ff_gnt3", s_gnt, 2'b01);
            if (c == 4) begin
                chk("ff_full_gnt", s_gnt, 0);
                chk("ff_full_cnt", s_cnt, 2);
            end
            if (c == 23) begin
                chk("ff_done_evt", s_evt, 2'b01);
                chk("ff_pop_gnt", s_gnt, 0);
                chk("ff_pop_cnt", s_cnt, 2);
            end
            if (c == 24) begin
                chk("ff_disp_start", s_start, 1);
                chk("ff_disp_cnt", s_cnt, 1);
                chk("ff_disp_gnt", s_gnt, 2'b10);
            end
            if (c == 25) chk("ff_refull", s_cnt, 2);
        end

        // Clear mid-RUN with two jobs queued; late done_i ignored.
        mode[0] = 0; mode[1] = 0; pend = '0;
        lat = -1; done_i = 1'b0;
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        done_i = 1'b1;
        cycle();
        chk("cl_cnt", s_cnt, 0);
        chk("cl_busy", s_busy, 0);
        chk("cl_evt", s_evt, 0);
        done_i = 1'b0;
        cycle();
        chk("cl_evt2", s_evt, 0);
        chk("cl_start", s_start, 0);
        chk("cl_busy2", s_busy, 0);

`ifdef MAC_JOB_SCHED_WATCHDOG_EN
        // Watchdog limit 5, no done_i: timeout 6 cycles after start.
        do_reset();
        wdl = 5; wd_limit = CW'(5);
        new_desc(0); new_desc(1);
        for (int c = 0; c < 11; c++) begin
            cycle();
            if (c == 2) chk("wd_start", s_start, 1);
            if (c == 7) chk("wd_early", s_evt, 0);
            if (c == 8) begin
                chk("wd_timeout", s_to, 2'b01);
                chk("wd_evt", s_evt, 2'b01);
            end
            if (c == 9) chk("wd_next", s_start, 1);
        end
`endif

        // Random traffic with random done_i, clears and resets.
        do_reset();
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
        wdl = $urandom_range(0, 8);
        wd_limit = CW'(wdl);
`endif
        mode[0] = 2; mode[1] = 2;
        lat = -2;
        repeat (3000) begin
            clear_i = ($urandom_range(0, 199) == 0);
            rst_i   = ($urandom_range(0, 499) == 0);
            cycle();
        end
        clear_i = 1'b0;
        rst_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
